fifo_rd_stream: RTL and testbench



---
 rtl/fifo_rd_stream_pkg.sv | 13 +
 rtl/fifo_rd_buf.sv | 56 +++++
 rtl/fifo_rd_stream.sv | 68 ++++++
 tb/tb_fifo_rd_stream.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_stream_pkg.sv
// Shared definitions for the FIFO read-side drain engine: RAM read latency, default
// counter width and the credit/occupancy width helper.
package fifo_rd_stream_pkg;

    localparam int unsigned FIFO_RD_LAT   = 1;
    localparam int unsigned DEFAULT_CNT_W = 16;

    // Occupancy must represent 0..depth inclusive, hence the extra bit.
    function automatic int unsigned credit_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_rd_buf.sv
// Synchronous circular register buffer with push/pop and occupancy output.
// Entries are cleared on reset so the head word reads as zero while empty.
module fifo_rd_buf
    import fifo_rd_stream_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic [credit_w(DEPTH)-1:0] occ
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = credit_w(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [OCC_W-1:0] occ_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   occ_q <= occ_q + OCC_W'(1);
                2'b01:   occ_q <= occ_q - OCC_W'(1);
                default: ;
            endcase
        end
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign occ      = occ_q;

    // The requester's credit rule must make an overflowing push unreachable.
    assert property (@(posedge clk) disable iff (rst) !(push && occ_q == OCC_W'(DEPTH)));

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side drain engine: issues rinc against rempty with buffer credits, absorbs the
// one-cycle FIFO RAM latency and re-presents the words as a valid/ready stream.
module fifo_rd_stream
    import fifo_rd_stream_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned BUF_DEPTH = 4,
    parameter int unsigned CNT_W     = DEFAULT_CNT_W
) (
    input  logic             rclk,
    input  logic             rrst,
    input  logic             rempty,
    output logic             rinc,
    input  logic [WIDTH-1:0] rdata,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] rd_count,
    output logic             busy
);

    localparam int unsigned OCC_W  = credit_w(BUF_DEPTH);
    localparam int unsigned CRED_W = OCC_W + 1;

    logic [OCC_W-1:0]  occ;
    logic [CRED_W-1:0] credit_used;
    logic              credit_ok;
    logic              inflight_q;
    logic [CNT_W-1:0]  rd_count_q;
    logic              pop;

    // Credits cover both stored words and the word still coming out of the RAM,
    // so a read is only issued when its data is guaranteed a free slot.
    assign credit_used = {1'b0, occ} + {{OCC_W{1'b0}}, inflight_q};
    assign credit_ok   = credit_used <= CRED_W'(BUF_DEPTH - 1);
    assign rinc        = ~rrst & ~rempty & credit_ok;

    always_ff @(posedge rclk) begin
        if (rrst) begin
            inflight_q <= 1'b0;
            rd_count_q <= '0;
        end else begin
            inflight_q <= rinc & ~rempty;
            if (pop) begin
                rd_count_q <= rd_count_q + CNT_W'(1);
            end
        end
    end

    assign out_valid = (occ != '0);
    assign pop       = out_valid & out_ready;
    assign busy      = out_valid | inflight_q;
    assign rd_count  = rd_count_q;

    fifo_rd_buf #(
        .WIDTH (WIDTH),
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk       (rclk),
        .rst       (rrst),
        .push      (inflight_q),
        .push_data (rdata),
        .pop       (pop),
        .pop_data  (out_data),
        .occ       (occ)
    );

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream with a same-clock FIFO model and a scoreboard queue.
module tb_fifo_rd_stream;

    logic        clk = 1'b0;
    logic        rrst;
    logic        rempty;
    logic        rinc;
    logic [7:0]  rdata = '0;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [15:0] rd_count;
    logic        busy;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  fmem[1024];
    int          head = 0;
    int          tail = 0;
    logic        force_empty = 1'b0;
    int          rc;

    always #5 clk = ~clk;

    fifo_rd_stream #(
        .WIDTH     (8),
        .BUF_DEPTH (4),
        .CNT_W     (16)
    ) dut (
        .rclk      (clk),
        .rrst      (rrst),
        .rempty    (rempty),
        .rinc      (rinc),
        .rdata     (rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .rd_count  (rd_count),
        .busy      (busy)
    );

    // FIFO model: registered read, data valid the cycle after an accepted read.
    assign rempty = (head == tail) || force_empty;

    always @(posedge clk) begin
        if (rinc && !rempty) begin
            rdata <= fmem[head % 1024];
            head  <= head + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic put(input logic [7:0] w);
        fmem[tail % 1024] = w;
        tail++;
        exp_q.push_back(w);
    endtask

    task automatic at_neg();
        @(negedge clk);
        check("rinc_while_empty", {31'b0, rinc & rempty}, 32'd0);
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL sb_extra: got word %0h expected none", out_data);
            end
            if (exp_q.size() != 0) check("sb_data", {24'b0, out_data}, {24'b0, exp_q.pop_front()});
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rrst      = 1'b1;
        out_ready = 1'b0;
        put(8'hA5);

        // Reset held with data available
        for (int i = 0; i < 3; i++) begin
            nxt();
            at_neg();
            check("rst_rinc", {31'b0, rinc}, 32'd0);
            check("rst_valid", {31'b0, out_valid}, 32'd0);
            check("rst_data", {24'b0, out_data}, 32'h00);
            check("rst_count", {16'b0, rd_count}, 32'd0);
            check("rst_busy", {31'b0, busy}, 32'd0);
        end
        nxt();

        // Single word: rinc c0, valid c2, counted c3
        rrst      = 1'b0;
        out_ready = 1'b1;
        at_neg();
        check("one_rinc_c0", {31'b0, rinc}, 32'd1);
        nxt();
        at_neg();
        check("one_rinc_c1", {31'b0, rinc}, 32'd0);
        check("one_valid_c1", {31'b0, out_valid}, 32'd0);
        nxt();
        at_neg();
        check("one_valid_c2", {31'b0, out_valid}, 32'd1);
        check("one_data_c2", {24'b0, out_data}, 32'hA5);
        nxt();
        at_neg();
        check("one_count_c3", {16'b0, rd_count}, 32'd1);
        check("one_busy_c3", {31'b0, busy}, 32'd0);
        nxt();

        // 16 words at full throughput
        for (int i = 0; i < 16; i++) put(8'(i));
        for (int c = 0; c < 20; c++) begin
            at_neg();
            if (c >= 2 && c <= 17) check("burst_valid", {31'b0, out_valid}, 32'd1);
            if (c == 18) check("burst_done", {31'b0, out_valid}, 32'd0);
            nxt();
        end
        check("burst_left", exp_q.size(), 32'd0);
        check("burst_count", {16'b0, rd_count}, 32'd17);

        // Backpressure: credits stop reads at 4
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) put(8'(i));
        rc = 0;
        for (int c = 0; c < 10; c++) begin
            at_neg();
            rc += int'(rinc);
            if (c >= 2) begin
                check("bp_valid", {31'b0, out_valid}, 32'd1);
                check("bp_data", {24'b0, out_data}, 32'h00);
            end
            nxt();
        end
        check("bp_reads", rc, 32'd4);
        out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            at_neg();
            nxt();
        end
        check("bp_left", exp_q.size(), 32'd0);
        check("bp_count", {16'b0, rd_count}, 32'd25);

        // Toggling rempty and random backpressure over 200 words
        for (int i = 0; i < 200; i++) put(8'($urandom_range(0, 255)));
        for (int c = 0; c < 3000 && exp_q.size() != 0; c++) begin
            force_empty = ~force_empty;
            out_ready   = 1'($urandom_range(0, 1));
            at_neg();
            nxt();
        end
        force_empty = 1'b0;
        out_ready   = 1'b1;
        for (int c = 0; c < 6; c++) begin
            at_neg();
            nxt();
        end
        check("rand_left", exp_q.size(), 32'd0);
        check("rand_count", {16'b0, rd_count}, 32'd225);

        // Reset with occ=3 and one read in flight
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) put(8'h80 + 8'(i));
        for (int c = 0; c < 4; c++) begin
            at_neg();
            check("mid_rinc", {31'b0, rinc}, 32'd1);
            nxt();
        end
        at_neg();
        check("mid_full_rinc", {31'b0, rinc}, 32'd0);
        check("mid_full_busy", {31'b0, busy}, 32'd1);
        rrst = 1'b1;
        nxt();
        rrst      = 1'b0;
        out_ready = 1'b1;
        // Words already read from the FIFO are lost by design
        while (exp_q.size() > tail - head) void'(exp_q.pop_front());
        at_neg();
        check("mid_valid", {31'b0, out_valid}, 32'd0);
        check("mid_count", {16'b0, rd_count}, 32'd0);
        check("mid_busy", {31'b0, busy}, 32'd0);
        check("mid_rinc_after", {31'b0, rinc}, 32'd1);
        nxt();
        for (int c = 0; c < 20; c++) begin
            at_neg();
            nxt();
        end
        check("mid_left", exp_q.size(), 32'd0);
        check("mid_count_end", {16'b0, rd_count}, 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
